// File: rtl/mbscore_muldiv_if.sv
// Execute-stage request/response bundle for the iterative mul/div unit.
// master = execute stage issuing ops, slave = the mul/div unit.
interface mbscore_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  req_ready, busy, done, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output req_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/mbscore_muldiv.sv
// Iterative one-bit-per-cycle multiply/divide unit holding HI/LO.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mbscore_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mbscore_muldiv_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc_hi;
  logic [W-1:0]   acc_lo;
  logic [W-1:0]   opb;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;
  logic           divz;
  logic           done_q;

  logic           accept;
  logic           signed_op;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     div_sh;
  logic [W:0]     div_diff;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

  assign bus.req_ready = (state == IDLE) & ~rst;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  // flush in IDLE swallows the request rather than queueing it
  assign accept    = bus.req_valid & bus.req_ready & ~bus.flush;
  assign signed_op = (bus.req_op == OP_MULT) | (bus.req_op == OP_DIV);
  assign a_neg     = signed_op & bus.req_a[W-1];
  assign b_neg     = signed_op & bus.req_b[W-1];
  assign a_mag     = a_neg ? (~bus.req_a + 1'b1) : bus.req_a;
  assign b_mag     = b_neg ? (~bus.req_b + 1'b1) : bus.req_b;

  assign mul_sum  = {1'b0, acc_hi}
                  + (acc_lo[0] ? {1'b0, opb} : {(W+1){1'b0}});
  assign div_sh   = {acc_hi, acc_lo[W-1]};
  assign div_diff = div_sh - {1'b0, opb};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  // zero divisor: remainder magnitude is |a|, so dividend sign restores a
  assign q_fix    = divz  ? {W{1'b1}}
                  : neg_q ? (~acc_lo + 1'b1) : acc_lo;
  assign r_fix    = neg_r ? (~acc_hi + 1'b1) : acc_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (bus.req_op)
              OP_MULT, OP_MULTU: begin
                acc_hi <= '0;
                acc_lo <= b_mag;
                opb    <= a_mag;
                is_div <= 1'b0;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= 1'b0;
                divz   <= 1'b0;
                cnt    <= '0;
                state  <= CALC;
              end
              OP_DIV, OP_DIVU: begin
                acc_hi <= '0;
                acc_lo <= a_mag;
                opb    <= b_mag;
                is_div <= 1'b1;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                divz   <= (bus.req_b == '0);
                cnt    <= '0;
                state  <= CALC;
              end
              OP_MTHI: begin
                hi_q   <= bus.req_a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.req_a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              acc_hi <= div_diff[W] ? div_sh[W-1:0]
                                    : div_diff[W-1:0];
              acc_lo <= {acc_lo[W-2:0], ~div_diff[W]};
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!bus.flush) begin
            if (is_div) begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbscore_muldiv.sv
// Randomized self-checking bench for mbscore_muldiv.
// Reference results come from plain 64-bit integer arithmetic.
module tb_mbscore_muldiv;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mbscore_muldiv_if #(.DATA_WIDTH(32)) bus ();

  mbscore_muldiv #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                inout logic [31:0] mh,
                                inout logic [31:0] ml);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; end
      3'd2: begin
        if (b == 0) begin mh = a; ml = '1; end
        else begin
          p = sa / sb; ml = p[31:0];
          p = sa % sb; mh = p[31:0];
        end
      end
      3'd3: begin
        if (b == 0) begin mh = a; ml = '1; end
        else begin ml = a / b; mh = a % b; end
      end
      3'd4: mh = a;
      3'd5: ml = a;
      default: ;
    endcase
  endfunction

  // caller is 1 time unit after a posedge; returns at the same phase
  task automatic start_op(input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom_range(0, 7));
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_n,
                           output bit seen);
    lat = 1; busy_n = 0; seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.flush = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    n_total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
      $display("FAIL reset_hilo: got %h/%h want 0/0", bus.hi, bus.lo);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_flags: busy=%b done=%b want 0/0", bus.busy, bus.done);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    int lat; int bn; bit seen;
    start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m_hi, m_lo);
    wait_done(lat, bn, seen);
    n_total++;
    if (!seen || lat !== 34)
      $display("FAIL multu_latency: seen=%b lat=%0d want 34", seen, lat);
    else n_pass++;
    n_total++;
    if (bn !== 33)
      $display("FAIL multu_busy: got %0d cycles want 33", bn);
    else n_pass++;
    n_total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL multu_result: got %h_%h want %h_%h", bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.done !== 1'b0)
      $display("FAIL multu_done_width: done=%b want 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; int bn; bit seen;
    start_op(3'd0, 32'hFFFF_FFF9, 32'd3);
    model(3'd0, 32'hFFFF_FFF9, 32'd3, m_hi, m_lo);
    wait_done(lat, bn, seen);
    n_total++;
    if (!seen || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL b2b_mult: seen=%b got %h_%h want %h_%h", seen, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    n_total++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL b2b_ready: got %b want 1", bus.req_ready);
    else n_pass++;
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    model(3'd2, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo);
    n_total++;
    if (bus.busy !== 1'b1)
      $display("FAIL b2b_accept: busy=%b want 1", bus.busy);
    else n_pass++;
    wait_done(lat, bn, seen);
    n_total++;
    if (!seen || lat !== 34 || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL b2b_div: seen=%b lat=%0d got %h_%h want %h_%h", seen, lat, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_div_special();
    int lat; int bn; bit seen;
    start_op(3'd3, 32'd100, 32'd0);
    model(3'd3, 32'd100, 32'd0, m_hi, m_lo);
    wait_done(lat, bn, seen);
    n_total++;
    if (!seen || lat !== 34 || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL divu_zero: seen=%b lat=%0d got %h_%h want %h_%h", seen, lat, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    @(posedge clk); #1;
    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, m_hi, m_lo);
    wait_done(lat, bn, seen);
    n_total++;
    if (!seen || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL div_overflow: seen=%b got %h_%h want %h_%h", seen, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    @(posedge clk); #1;
    start_op(3'd2, 32'hFFFF_FF9C, 32'd0);
    model(3'd2, 32'hFFFF_FF9C, 32'd0, m_hi, m_lo);
    wait_done(lat, bn, seen);
    n_total++;
    if (!seen || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL div_zero_neg: seen=%b got %h_%h want %h_%h", seen, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] old_lo;
    old_lo = m_lo;
    n_total++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL mt_ready0: got %b want 1", bus.req_ready);
    else n_pass++;
    start_op(3'd4, 32'h1234_5678, 32'h0);
    model(3'd4, 32'h1234_5678, 32'h0, m_hi, m_lo);
    n_total++;
    if (bus.hi !== m_hi || bus.lo !== old_lo || bus.done !== 1'b1)
      $display("FAIL mthi: got %h_%h done=%b want %h_%h done=1", bus.hi, bus.lo, bus.done, m_hi, old_lo);
    else n_pass++;
    n_total++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL mt_ready1: got %b want 1", bus.req_ready);
    else n_pass++;
    start_op(3'd5, 32'h9ABC_DEF0, 32'h0);
    model(3'd5, 32'h9ABC_DEF0, 32'h0, m_hi, m_lo);
    n_total++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== m_lo || bus.done !== 1'b1)
      $display("FAIL mtlo: got %h_%h done=%b want %h_%h done=1", bus.hi, bus.lo, bus.done, 32'h1234_5678, m_lo);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.done !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL mt_after: done=%b ready=%b want 0/1", bus.done, bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_flush();
    int lat; int bn; bit seen; int dones;
    start_op(3'd4, 32'h0000_AAAA, 32'h0);
    start_op(3'd5, 32'h0000_5555, 32'h0);
    m_hi = 32'h0000_AAAA; m_lo = 32'h0000_5555;
    @(posedge clk); #1;
    start_op(3'd3, 32'd1000, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_total++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL flush_idle: busy=%b ready=%b want 0/1", bus.busy, bus.req_ready);
    else n_pass++;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    n_total++;
    if (dones !== 0)
      $display("FAIL flush_nodone: got %0d pulses want 0", dones);
    else n_pass++;
    n_total++;
    if (bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL flush_hold: got %h_%h want %h_%h", bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    // flush in IDLE must block acceptance
    bus.flush = 1'b1;
    start_op(3'd4, 32'hDEAD_BEEF, 32'h0);
    bus.flush = 1'b0;
    n_total++;
    if (bus.hi !== m_hi || bus.done !== 1'b0)
      $display("FAIL flush_block: hi=%h done=%b want %h/0", bus.hi, bus.done, m_hi);
    else n_pass++;
    start_op(3'd3, 32'd1000, 32'd7);
    model(3'd3, 32'd1000, 32'd7, m_hi, m_lo);
    wait_done(lat, bn, seen);
    n_total++;
    if (!seen || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL flush_reissue: seen=%b got %h_%h want %h_%h", seen, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a; logic [31:0] b;
    logic [31:0] ph; logic [31:0] pl;
    int lat; int bn; bit seen;
    for (int k = 0; k < 24; k++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      ph = m_hi; pl = m_lo;
      start_op(op, a, b);
      model(op, a, b, m_hi, m_lo);
      if (op < 3'd4) begin
        wait_done(lat, bn, seen);
        n_total++;
        if (!seen || lat !== 34 || bus.hi !== m_hi || bus.lo !== m_lo)
          $display("FAIL rand_op%0d a=%h b=%h: seen=%b lat=%0d got %h_%h want %h_%h", op, a, b, seen, lat, bus.hi, bus.lo, m_hi, m_lo);
        else n_pass++;
      end else if (op < 3'd6) begin
        n_total++;
        if (bus.done !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
          $display("FAIL rand_mt%0d: done=%b got %h_%h want %h_%h", op, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        else n_pass++;
      end else begin
        n_total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== ph || bus.lo !== pl)
          $display("FAIL rand_illegal%0d: done=%b busy=%b got %h_%h want %h_%h", op, bus.done, bus.busy, bus.hi, bus.lo, ph, pl);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    int dones;
    start_op(3'd4, 32'h5A5A_5A5A, 32'h0);
    start_op(3'd1, 32'h0001_2345, 32'h0006_7890);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL arst_state: hi=%h lo=%h busy=%b done=%b want 0", bus.hi, bus.lo, bus.busy, bus.done);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    n_total++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL arst_ready: got %b want 1", bus.req_ready);
    else n_pass++;
    @(posedge clk); #1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    n_total++;
    if (dones !== 0 || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL arst_nodone: pulses=%0d hi=%h lo=%h want 0", dones, bus.hi, bus.lo);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div_special();
    test_mthi_mtlo();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mbscore_muldiv.md
Name: mbscore_muldiv

Overview:
- Iterative multiply/divide responder for the MBScore integer pipeline; the execute stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests to it.
- Computes one operand bit per cycle (shift-add multiply, restoring divide) and holds the architectural HI/LO registers.
- Serves the multi-cycle half of the execute interface that the single-cycle ALU does not cover; signals completion with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 illegal.
- req_a  in  DATA_WIDTH  multiplicand/dividend, or MTHI/MTLO source.
- req_b  in  DATA_WIDTH  multiplier/divisor.
- flush  in  1  synchronous abort of an in-flight operation.
- busy  out  1  high in CALC or FIX.
- done  out  1  one-cycle completion pulse.
- hi  out  DATA_WIDTH  HI register (product high half / remainder).
- lo  out  DATA_WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (async) forces: state IDLE, hi=0, lo=0, done=0, busy=0, req_ready=1, counter=0. Reset mid-operation discards the operation; no done pulse.
- Accept: req_valid & req_ready sampled at a posedge (edge T). Operands are latched at T, so req_a/req_b may change afterwards.
- FSM states and transitions:
  - IDLE -> CALC on an accepted op 0-3.
  - CALC -> FIX after exactly DATA_WIDTH iterations (edges T+1..T+32).
  - FIX -> IDLE at edge T+33, which also writes hi/lo and sets done.
  - Result: done is high for exactly one cycle, following edge T+33. hi/lo are valid in that same cycle. Latency = 34 cycles from accept to done.
- done and req_ready are both high in the done cycle. A new request is accepted in that cycle (back-to-back issue).
- Signed ops (MULT, DIV):
  - Magnitudes are taken at accept and the core is computed unsigned.
  - FIX negates the product if the operand signs differ.
  - FIX negates the quotient if the signs differ; the remainder takes the sign of the dividend (truncating division).
- MULT/MULTU: {hi,lo} = full 2*DATA_WIDTH product; no truncation.
- Divide by zero (req_b=0, DIV or DIVU): full latency still applies. Result hi=req_a, lo=all ones.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- MTHI/MTLO:
  - Write hi or lo from req_a at the accept edge; the other register is unchanged.
  - FSM stays in IDLE. done pulses in the next cycle, and a further request can be accepted in that cycle.
- Illegal op (6, 7): accepted, no state or register change, no done.
- flush:
  - In CALC or FIX: return to IDLE at the next edge; hi/lo unchanged; no done.
  - In IDLE: no effect, but it blocks acceptance that cycle (flush has priority over req_valid).
- hi/lo change only at a FIX completion edge or an MTHI/MTLO accept edge. They hold otherwise, including across flushes.
- busy = (state != IDLE); req_ready = (state == IDLE) & ~rst.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 34 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=-7 (0xFFFFFFF9), b=3, issued back-to-back with DIV a=-7, b=2 in the done cycle:
  - first result: hi=0xFFFFFFFF, lo=0xFFFFFFEB;
  - second result: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF after 34 cycles. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive accept cycles -> hi/lo update at the respective edges; one done pulse each; req_ready never drops.
- Start DIVU 1000/7 with hi/lo preset to 0xAAAA/0x5555; assert flush at cycle 10 -> IDLE next edge; hi/lo remain 0xAAAA/0x5555; no done. Re-issue -> lo=142, hi=6.
- Assert rst asynchronously mid-CALC (between clock edges) -> hi=lo=0, req_ready=1, busy=0 immediately; no done pulse after rst release.
